// File: rtl/tdm_demux4_if.sv
// Bus bundle for the TDM 1-to-4 demultiplexer: serial sample input side and
// rebuilt parallel frame output side.
interface tdm_demux4_if #(
  parameter int W = 1
) ();
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_sof;
  logic [4*W-1:0]   out_data;
  logic             out_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;

  // Sender / environment side: drives samples, observes frames.
  modport master (
    output in_valid, in_data, in_sof,
    input  out_data, out_valid, slot, locked, sync_err
  );

  // Demultiplexer side: consumes samples, produces frames.
  modport slave (
    input  in_valid, in_data, in_sof,
    output out_data, out_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// TDM 1-to-4 demultiplexer: receive end of a 4:1 TDM link. Stages lanes 0..2,
// then publishes the whole frame at once when the slot-3 sample arrives. A
// start-of-frame marker on slot 0 establishes and maintains alignment.
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  tdm_demux4_if.slave        bus
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic [W-1:0]      lane0_q, lane0_d;
  logic [W-1:0]      lane1_q, lane1_d;
  logic [W-1:0]      lane2_q, lane2_d;
  logic [4*W-1:0]    out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sync_err_q, sync_err_d;

  // State, staging and output registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      lane0_q     <= '0;
      lane1_q     <= '0;
      lane2_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      lane0_q     <= lane0_d;
      lane1_q     <= lane1_d;
      lane2_q     <= lane2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  // Framing FSM: next state, slot advance, lane staging and pulse outputs.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    lane0_d     = lane0_q;
    lane1_d     = lane1_q;
    lane2_d     = lane2_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.in_sof) begin
            lane0_d = bus.in_data;
            slot_d  = 2'd1;
            state_d = SYNC;
          end else begin
            // Unaligned and no marker: discard silently.
            slot_d  = 2'd0;
          end
        end
        SYNC: begin
          if (bus.in_sof) begin
            // A marker anywhere but slot 0 means the partial frame is bad;
            // flag it, but the marker itself realigns us immediately.
            sync_err_d = (slot_q != 2'd0) ? 1'b1 : 1'b0;
            lane0_d    = bus.in_data;
            slot_d     = 2'd1;
          end else begin
            case (slot_q)
              2'd0: begin
                // Slot 0 must carry the marker: alignment lost.
                sync_err_d = 1'b1;
                slot_d     = 2'd0;
                state_d    = HUNT;
              end
              2'd1: begin
                lane1_d = bus.in_data;
                slot_d  = 2'd2;
              end
              2'd2: begin
                lane2_d = bus.in_data;
                slot_d  = 2'd3;
              end
              2'd3: begin
                // Last lane goes straight to the output with the staged ones.
                out_data_d  = {bus.in_data, lane2_q, lane1_q, lane0_q};
                out_valid_d = 1'b1;
                slot_d      = 2'd0;
              end
              default: begin
                slot_d = 2'd0;
              end
            endcase
          end
        end
        default: begin
          state_d = HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end else begin
      // Gap: hold everything.
      state_d = state_q;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot      = slot_q;
  assign bus.locked    = (state_q == SYNC);
  assign bus.sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: table of per-cycle vectors on a W=4 instance,
// plus hand sequences for W=1 and asynchronous reset.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;

  tdm_demux4_if #(.W(4)) b4 ();
  tdm_demux4_if #(.W(1)) b1 ();

  tdm_demux4 #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  tdm_demux4 #(.W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        sof;
    logic [3:0]  d;
    logic        ov;
    logic        se;
    logic [1:0]  slot;
    logic        lk;
    logic [15:0] od;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_errors;

  task automatic add(input logic v, input logic sof, input logic [3:0] d,
                     input logic ov, input logic se, input logic [1:0] slot,
                     input logic lk, input logic [15:0] od);
    vec_t x;
    x.v = v; x.sof = sof; x.d = d; x.ov = ov; x.se = se;
    x.slot = slot; x.lk = lk; x.od = od;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input int idx, input logic ov,
                      input logic se, input logic [1:0] slot, input logic lk,
                      input logic [15:0] od);
    chk({tag, ".out_valid"}, idx, {15'd0, b4.out_valid}, {15'd0, ov});
    chk({tag, ".sync_err"},  idx, {15'd0, b4.sync_err},  {15'd0, se});
    chk({tag, ".slot"},      idx, {14'd0, b4.slot},      {14'd0, slot});
    chk({tag, ".locked"},    idx, {15'd0, b4.locked},    {15'd0, lk});
    chk({tag, ".out_data"},  idx, b4.out_data,           od);
  endtask

  task automatic step4(input logic v, input logic sof, input logic [3:0] d);
    b4.in_valid = v;
    b4.in_sof   = sof;
    b4.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] bits;
    n_checks = 0;
    n_errors = 0;
    b4.in_valid = 1'b0; b4.in_sof = 1'b0; b4.in_data = 4'h0;
    b1.in_valid = 1'b0; b1.in_sof = 1'b0; b1.in_data = 1'b0;

    // Back-to-back frames {A,B,C,D} then {1,2,3,4}
    add(1'b1,1'b1,4'hA, 1'b0,1'b0,2'd1,1'b1,16'h0000);
    add(1'b1,1'b0,4'hB, 1'b0,1'b0,2'd2,1'b1,16'h0000);
    add(1'b1,1'b0,4'hC, 1'b0,1'b0,2'd3,1'b1,16'h0000);
    add(1'b1,1'b0,4'hD, 1'b1,1'b0,2'd0,1'b1,16'hDCBA);
    add(1'b1,1'b1,4'h1, 1'b0,1'b0,2'd1,1'b1,16'hDCBA);
    add(1'b1,1'b0,4'h2, 1'b0,1'b0,2'd2,1'b1,16'hDCBA);
    add(1'b1,1'b0,4'h3, 1'b0,1'b0,2'd3,1'b1,16'hDCBA);
    add(1'b1,1'b0,4'h4, 1'b1,1'b0,2'd0,1'b1,16'h4321);
    // Frame {E,F,0,1} with a gap after every sample; sof ignored when idle
    add(1'b1,1'b1,4'hE, 1'b0,1'b0,2'd1,1'b1,16'h4321);
    add(1'b0,1'b1,4'h7, 1'b0,1'b0,2'd1,1'b1,16'h4321);
    add(1'b1,1'b0,4'hF, 1'b0,1'b0,2'd2,1'b1,16'h4321);
    add(1'b0,1'b0,4'h7, 1'b0,1'b0,2'd2,1'b1,16'h4321);
    add(1'b1,1'b0,4'h0, 1'b0,1'b0,2'd3,1'b1,16'h4321);
    add(1'b0,1'b1,4'h7, 1'b0,1'b0,2'd3,1'b1,16'h4321);
    add(1'b1,1'b0,4'h1, 1'b1,1'b0,2'd0,1'b1,16'h10FE);
    add(1'b0,1'b1,4'h7, 1'b0,1'b0,2'd0,1'b1,16'h10FE);
    // Slot 0 without sof: alignment lost
    add(1'b1,1'b0,4'h7, 1'b0,1'b1,2'd0,1'b0,16'h10FE);
    add(1'b0,1'b0,4'h0, 1'b0,1'b0,2'd0,1'b0,16'h10FE);
    // HUNT: three samples without sof are discarded, then frame 5,6,7,8
    add(1'b1,1'b0,4'h1, 1'b0,1'b0,2'd0,1'b0,16'h10FE);
    add(1'b1,1'b0,4'h2, 1'b0,1'b0,2'd0,1'b0,16'h10FE);
    add(1'b1,1'b0,4'h3, 1'b0,1'b0,2'd0,1'b0,16'h10FE);
    add(1'b1,1'b1,4'h5, 1'b0,1'b0,2'd1,1'b1,16'h10FE);
    add(1'b1,1'b0,4'h6, 1'b0,1'b0,2'd2,1'b1,16'h10FE);
    add(1'b1,1'b0,4'h7, 1'b0,1'b0,2'd3,1'b1,16'h10FE);
    add(1'b1,1'b0,4'h8, 1'b1,1'b0,2'd0,1'b1,16'h8765);
    // Early sof at slot 2, then 9,A,B complete a frame with lane0 = 3
    add(1'b1,1'b1,4'h1, 1'b0,1'b0,2'd1,1'b1,16'h8765);
    add(1'b1,1'b0,4'h2, 1'b0,1'b0,2'd2,1'b1,16'h8765);
    add(1'b1,1'b1,4'h3, 1'b0,1'b1,2'd1,1'b1,16'h8765);
    add(1'b1,1'b0,4'h9, 1'b0,1'b0,2'd2,1'b1,16'h8765);
    add(1'b1,1'b0,4'hA, 1'b0,1'b0,2'd3,1'b1,16'h8765);
    add(1'b1,1'b0,4'hB, 1'b1,1'b0,2'd0,1'b1,16'hBA93);
    // Early sof at slot 3 discards the frame as well
    add(1'b1,1'b1,4'hC, 1'b0,1'b0,2'd1,1'b1,16'hBA93);
    add(1'b1,1'b0,4'hC, 1'b0,1'b0,2'd2,1'b1,16'hBA93);
    add(1'b1,1'b0,4'hC, 1'b0,1'b0,2'd3,1'b1,16'hBA93);
    add(1'b1,1'b1,4'h6, 1'b0,1'b1,2'd1,1'b1,16'hBA93);
    add(1'b0,1'b0,4'h0, 1'b0,1'b0,2'd1,1'b1,16'hBA93);

    // Reset state
    rst_n = 1'b0;
    #12;
    chk4("reset", 0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
    chk("reset.w1_data", 0, {12'd0, b1.out_data}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step4(vecs[i].v, vecs[i].sof, vecs[i].d);
      chk4("vec", i, vecs[i].ov, vecs[i].se, vecs[i].slot, vecs[i].lk, vecs[i].od);
    end

    // W=1: sof+1,0,1,1 gives 4'b1101, one-cycle pulse
    bits = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      b1.in_valid = 1'b1;
      b1.in_sof   = (k == 0);
      b1.in_data  = bits[k];
      @(posedge clk);
      #1;
      chk("w1.out_valid", k, {15'd0, b1.out_valid}, {15'd0, (k == 3)});
    end
    chk("w1.out_data", 4, {12'd0, b1.out_data}, 16'h000D);
    b1.in_valid = 1'b0;
    b1.in_sof   = 1'b0;
    @(posedge clk);
    #1;
    chk("w1.pulse_end", 5, {15'd0, b1.out_valid}, 16'h0000);
    chk("w1.hold", 5, {12'd0, b1.out_data}, 16'h000D);

    // Async reset mid-frame: outputs clear without a clock edge
    step4(1'b1, 1'b1, 4'h1);
    step4(1'b1, 1'b0, 4'h2);
    chk4("pre_rst", 0, 1'b0, 1'b0, 2'd2, 1'b1, 16'hBA93);
    b4.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst", 0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
    chk("async_rst.w1", 0, {12'd0, b1.out_data}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Back in HUNT: non-sof discarded, then a fresh frame 4,3,2,1
    step4(1'b1, 1'b0, 4'h9);
    chk4("post_rst", 0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000);
    step4(1'b1, 1'b1, 4'h4);
    step4(1'b1, 1'b0, 4'h3);
    step4(1'b1, 1'b0, 4'h2);
    chk4("post_rst", 1, 1'b0, 1'b0, 2'd3, 1'b1, 16'h0000);
    step4(1'b1, 1'b0, 4'h1);
    chk4("post_rst", 2, 1'b1, 1'b0, 2'd0, 1'b1, 16'h1234);
    step4(1'b0, 1'b0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
